// File: rtl/ex_mem_pipe_pkg.sv
// Shared EX->MEM definitions: field widths, NOP encodings, the bundle layout
// and the controller's stall-vector bit positions.
package pipe_defs;

    localparam int DATA_W_DEF  = 32;
    localparam int PC_W_DEF    = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int WE_W_DEF    = 4;
    localparam int ALUOP_W_DEF = 8;

    localparam logic [ALUOP_W_DEF-1:0] ALUOP_NOP = '0;
    localparam logic [WE_W_DEF-1:0]    WREG_DIS  = '0;

    typedef struct packed {
        logic                   valid;
        logic [RADDR_W_DEF-1:0] wd;
        logic [WE_W_DEF-1:0]    wreg;
        logic [DATA_W_DEF-1:0]  wdata;
        logic [ALUOP_W_DEF-1:0] aluop;
        logic [DATA_W_DEF-1:0]  mem_addr;
        logic [DATA_W_DEF-1:0]  reg2;
        logic [PC_W_DEF-1:0]    pc;
    } ex_mem_bundle_t;

    // Bit positions within the controller's stall vector.
    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    function automatic logic [2:0] count_valid(input logic [3:0] v);
        count_valid = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/ex_mem_pipe_slice.sv
// One register slice of the EX->MEM pipe; clear beats hold beats bubble beats load.
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (hold) begin
            q <= q;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with DEPTH retiming slices, stall/bubble/flush
// control and a registered count of valid slices.
module ex_mem_pipe
    import pipe_defs::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RADDR_W = 5,
    parameter int WE_W    = 4,
    parameter int ALUOP_W = 8,
    parameter int DEPTH   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_stall,
    input  logic               mem_stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [RADDR_W-1:0] ex_wd,
    input  logic [WE_W-1:0]    ex_wreg,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic [ALUOP_W-1:0] ex_aluop,
    input  logic [DATA_W-1:0]  ex_mem_addr,
    input  logic [DATA_W-1:0]  ex_reg2,
    input  logic [PC_W-1:0]    ex_pc,
    output logic               mem_valid,
    output logic [RADDR_W-1:0] mem_wd,
    output logic [WE_W-1:0]    mem_wreg,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [ALUOP_W-1:0] mem_aluop,
    output logic [DATA_W-1:0]  mem_mem_addr,
    output logic [DATA_W-1:0]  mem_reg2,
    output logic [PC_W-1:0]    mem_pc,
    output logic [2:0]         occupancy
);

    localparam int BW = 1 + RADDR_W + WE_W + DATA_W + ALUOP_W + DATA_W + DATA_W + PC_W;

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("ex_mem_pipe: DEPTH must be within 1..4");
    end

    logic [BW-1:0]    ex_bundle;
    logic [BW-1:0]    slice_d [DEPTH];
    logic [BW-1:0]    slice_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_next;
    logic [2:0]       occ_q;

    // An invalid instruction must never write or issue a memory op downstream.
    assign ex_bundle = {ex_valid,
                        ex_wd,
                        ex_valid ? ex_wreg  : WE_W'(WREG_DIS),
                        ex_wdata,
                        ex_valid ? ex_aluop : ALUOP_W'(ALUOP_NOP),
                        ex_mem_addr,
                        ex_reg2,
                        ex_pc};

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        if (k == 0) begin : g_head
            assign slice_d[k] = ex_bundle;
        end else begin : g_tail
            assign slice_d[k] = slice_q[k-1];
        end

        pipe_slice #(.W(BW)) u_slice (
            .clk    (clk),
            .rst    (rst),
            .clear  (flush),
            .hold   (mem_stall),
            .bubble (ex_stall && (k == 0)),
            .d      (slice_d[k]),
            .q      (slice_q[k])
        );

        assign valid_q[k] = slice_q[k][BW-1];
    end

    always_comb begin
        valid_next = valid_q;
        if (flush) begin
            valid_next = '0;
        end else if (!mem_stall) begin
            valid_next[0] = ex_valid && !ex_stall;
            for (int k = 1; k < DEPTH; k++) begin
                valid_next[k] = valid_q[k-1];
            end
        end
    end

    // Counting the next-state valid bits keeps occupancy in step with the slices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= count_valid(4'(valid_next));
        end
    end

    assign occupancy = occ_q;

    assign {mem_valid, mem_wd, mem_wreg, mem_wdata, mem_aluop,
            mem_mem_addr, mem_reg2, mem_pc} = slice_q[DEPTH-1];

endmodule
